instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch/sequencing stage that sits directly upstream of the Op decoder (`controller`). It holds the program counter and reads 16-bit instructions from a synchronous instruction ROM. It latches each instruction into an instruction register and splits it into the `op`/register/immediate fields that drive the decoder and register file. It also resolves the three opcodes the decoder leaves unused (13 BZ, 14 JMP, 15 HLT) as control-flow.

## Interface
Parameters:
- `PC_W`, 8: program-counter and ROM address width. Legal range is 4..8; PC arithmetic wraps mod 2^PC_W.
- `MEM_LAT`, 1: ROM read latency in cycles. Legal range is 1..3.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  downstream hold; keeps the current instruction issued.
- `zero_flag`  in  1  Z bit from the flag register.
- `imem_rden`  out  1  ROM read enable.
- `imem_addr`  out  PC_W  ROM address; equals `pc`.
- `imem_q`  in  16  ROM read data.
- `op`  out  4  IR[15:12]; feeds the decoder's `Op`.
- `rd`  out  4  IR[11:8].
- `rs`  out  4  IR[7:4].
- `rt`  out  4  IR[3:0]; also serves as the 4-bit immediate.
- `imm8`  out  8  IR[7:0]; branch offset / jump target.
- `pc`  out  PC_W  address of the instruction currently in IR.
- `instr_valid`  out  1  IR holds an issued instruction.
- `halted`  out  1  core is stopped by HLT.

## Operation
- Reset values:
  - `pc`=0; IR=16'h0000, so `op`/`rd`/`rs`/`rt`/`imm8` are all 0.
  - `instr_valid`=0, `imem_rden`=0, `halted`=0.
  - State = FETCH.
- State FETCH (1 cycle):
  - `imem_rden`=1, `imem_addr`=`pc`.
  - Next state: WAIT, with the wait counter loaded to MEM_LAT-1.
- State WAIT (MEM_LAT cycles):
  - `imem_rden`=0; the counter decrements each cycle.
  - In the cycle where the counter reads 0, `imem_q` is valid. IR loads `imem_q` on that edge and the state moves to ISSUE.
- State ISSUE (≥1 cycle): `instr_valid`=1 for the whole state.
  - If `stall`=1: IR, `pc` and the state all hold.
  - If `stall`=0: the next PC is computed from IR and `zero_flag` (both sampled this cycle), then:
    - Op 0–12 and 7 (7 is reserved and treated as a NOP): `pc`+1 → FETCH.
    - Op 13 BZ: if `zero_flag`=1, `pc` + sign-extend(`imm8`) truncated to PC_W; else `pc`+1. Next state FETCH.
    - Op 14 JMP: `pc` = `imm8`[PC_W-1:0] → FETCH.
    - Op 15 HLT: `pc` unchanged → HALT.
- State HALT:
  - `halted`=1, `instr_valid`=0, `imem_rden`=0.
  - IR keeps the HLT word. `stall` is ignored.
  - The only exit is `rst`.
- The decoder and register-file write act during ISSUE. A flag written by instruction N is therefore visible to a BZ at N+1.
- Wrap-around: `pc`=2^PC_W-1 plus 1 → 0. Branch targets wrap the same way; there is no fault.
- BZ with offset 0 re-executes itself. This is legal and is used as a spin-until-flag construct.

## Timing
- The instruction at `pc` is issued MEM_LAT+1 cycles after its FETCH cycle.
- Unstalled throughput is one instruction per MEM_LAT+2 cycles, with no overlap between fetches.
- All outputs are registered. `op` and the other IR fields change only on the edge that enters ISSUE, or on reset.
- `instr_valid` rises on the edge that enters ISSUE. It falls on the edge that leaves ISSUE.
- `rst` in any state, including WAIT with a read outstanding, forces reset values on the next edge. Any late `imem_q` is ignored.
- `stall` asserted in FETCH or WAIT has no effect. It only holds ISSUE.
- `rst` and `stall` both high: `rst` wins.

## Configuration
- `IFU_BRANCH_EN` defined:
  - Op 13 (BZ) and Op 14 (JMP) redirect `pc` as described under Operation.
- `IFU_BRANCH_EN` undefined:
  - Op 13/14 behave as NOPs (`pc`+1).
  - `zero_flag` is unused.
  - The next-PC adder/mux for branches is not synthesized.
- HLT (Op 15) is decoded in both builds.

## Test plan
- Reset and sequential fetch:
  - Stimulus: MEM_LAT=1; ROM[0..2] = 16'h0123, 16'h8456, 16'hF000.
  - Required: `op` = 0, 8, 15 on `instr_valid` every 3 cycles; `pc` = 0, 1, 2; then `halted`=1 with `pc` held at 2.
- Stall hold:
  - Stimulus: assert `stall` for 4 cycles during ISSUE of ROM[1].
  - Required: `instr_valid` high for 5 cycles; `op`/`pc` unchanged; next FETCH address = 2.
- Branch (IFU_BRANCH_EN defined):
  - Stimulus: ROM[5] = 16'hD0FE.
  - With `zero_flag`=1: next `pc` = 3 (5-2).
  - With `zero_flag`=0: next `pc` = 6.
  - Stimulus: JMP 16'hE0A0 with PC_W=8. Required: next `pc` = 0xA0.
- Wrap-around:
  - Stimulus: PC_W=4, JMP to 15, ROM[15] = NOP.
  - Required: next fetch at `pc` = 0.
- Latency:
  - Stimulus: MEM_LAT=3.
  - Required: `imem_rden` pulses every 5 cycles; IR loads exactly 3 cycles after each pulse.
- Reset mid-WAIT:
  - Stimulus: `rst` pulsed during WAIT.
  - Required: next cycle `pc`=0, `instr_valid`=0, state FETCH; the stale `imem_q` is never issued.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing stage: PC, ROM read sequencing, IR field split, BZ/JMP/HLT resolution.
// Define IFU_BRANCH_EN to enable BZ/JMP redirection; otherwise Op 13/14 fall through as NOPs.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            zero_flag,
  output logic            imem_rden,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_q,
  output logic [3:0]      op,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [7:0]      imm8,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state_r;
  logic [15:0]     ir_r;
  logic [PC_W-1:0] pc_r;
  logic [1:0]      cnt_r;
  logic            rden_r;
  logic            valid_r;
  logic            halted_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] next_pc_s;

  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef IFU_BRANCH_EN
  // Next-PC select; sign-extending imm8 then truncating to PC_W (<= 8) is just its low PC_W bits.
  always_comb begin
    next_pc_s = pc_inc_s;
    case (ir_r[15:12])
      4'd13: begin
        if (zero_flag) begin
          next_pc_s = pc_r + ir_r[PC_W-1:0];
        end else begin
          next_pc_s = pc_inc_s;
        end
      end
      4'd14:   next_pc_s = ir_r[PC_W-1:0];
      default: next_pc_s = pc_inc_s;
    endcase
  end
`else
  logic unused_zero_flag_s;
  assign unused_zero_flag_s = zero_flag;
  assign next_pc_s = pc_inc_s;
`endif

  // Sequencer FSM. rden is a register, so the FETCH entered by reset spends one
  // extra cycle raising it; FETCH entered from ISSUE arrives with rden already high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= FETCH;
      ir_r     <= 16'h0000;
      pc_r     <= {PC_W{1'b0}};
      cnt_r    <= 2'd0;
      rden_r   <= 1'b0;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (rden_r) begin
            rden_r  <= 1'b0;
            cnt_r   <= 2'(MEM_LAT - 1);
            state_r <= WAIT;
          end else begin
            rden_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r == 2'd0) begin
            ir_r    <= imem_q;
            valid_r <= 1'b1;
            state_r <= ISSUE;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            valid_r <= 1'b0;
            if (ir_r[15:12] == 4'hF) begin
              halted_r <= 1'b1;
              state_r  <= HALT;
            end else begin
              pc_r    <= next_pc_s;
              rden_r  <= 1'b1;
              state_r <= FETCH;
            end
          end else begin
            valid_r <= 1'b1;
          end
        end
        HALT: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= FETCH;
          rden_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_rden   = rden_r;
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign op          = ir_r[15:12];
  assign rd          = ir_r[11:8];
  assign rs          = ir_r[7:4];
  assign rt          = ir_r[3:0];
  assign imm8        = ir_r[7:0];
  assign instr_valid = valid_r;
  assign halted      = halted_r;

endmodule
